datapath_mc: RTL and testbench
==============================

Name: datapath_mc

Overview:
- Parametrised multi-cycle successor of the register-file/ALU datapath.
- Accepts one operation per handshake and sequences it internally: read A, read B, execute, write-back.
- Supports generic word width and register count, selectable write-back source, and optional flag update.
- Sits between the instruction decoder/controller and memory; exposes a result register, status flags and a done pulse.

Parameters:
- W, 16, datapath word width; must be at least 8.
- AW, 3, register address width; NREG = 2**AW registers.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  operation request.
- op_ready  out  1  high only in IDLE; an op is accepted on a clk edge where op_valid & op_ready.
- alu_op  in  2  00 add, 01 sub, 10 and, 11 not-B.
- shift  in  2  B-operand shift: 00 none, 01 lsl1, 10 lsr1, 11 asr1.
- rn  in  AW  A source register.
- rm  in  AW  B source register.
- rd  in  AW  destination register.
- wsrc  in  2  write-back source: 00 ALU result, 01 mdata, 10 sext(imm8), 11 zero-extended pc.
- wr_en  in  1  write rd in WB.
- zero_a  in  1  force A operand to 0.
- use_imm  in  1  B operand = sext(imm5) instead of shifted B.
- set_flags  in  1  update flags in EXE.
- imm5  in  5  immediate, sign-extended to W.
- imm8  in  8  immediate, sign-extended to W.
- mdata  in  W  memory read data.
- pc  in  9  program counter.
- result  out  W  C register (last ALU result).
- flags  out  3  {Z,V,N} status register.
- done  out  1  one-cycle pulse in the WB state.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all NREG registers, A, B, result and flags = 0; done=0; op_ready=1 once rst_n rises.
- Acceptance:
  - At acceptance, all op fields, imm5, imm8, mdata and pc are captured into an op register.
  - Inputs are don't-care afterwards.
- FSM states: IDLE, LDA, LDB, EXE, WB.
  - IDLE: op_ready=1. On accept, go to LDA if wsrc==00, else go to WB.
  - LDA: A <= regfile[rn]; go to LDB.
  - LDB: B <= regfile[rm]; go to EXE.
  - EXE:
    - Ain = zero_a ? 0 : A.
    - Bin = use_imm ? sext(imm5) : shift(B).
    - result <= ALU(Ain,Bin).
    - If set_flags: flags <= {Z,V,N}; otherwise flags hold.
    - Go to WB.
  - WB:
    - done=1.
    - If wr_en, regfile[rd] <= selected source on this edge.
    - Go to IDLE.
    - The next op can be accepted on the following cycle.
- Latency, accept edge to done high:
  - wsrc==00: 4 cycles (LDA, LDB, EXE, WB).
  - wsrc!=00: 1 cycle (WB only). result and flags are untouched.
  - Throughput: one op per 5 cycles (ALU path) or per 2 cycles (direct path).
- Arithmetic (all modulo 2**W):
  - lsl1 shifts in 0; lsr1 shifts in 0; asr1 replicates the MSB.
  - Z = (out==0); N = out[W-1].
  - V: add is signed overflow of Ain+Bin; sub is signed overflow of Ain−Bin; and/not force V=0.
- Boundary and corner cases:
  - op_valid while not IDLE: ignored and not queued.
  - rd equal to rn or rm: reads precede the write, so no hazard.
  - wsrc==00 with wr_en=0 (compare): flags and result update; no register changes.
  - The dbg_data read reflects the write only after the WB edge.
  - rst_n asserted in any state: immediate return to IDLE. A pending write is lost; done deasserts asynchronously.

Test Plan:
- Reset → rst_n=0 mid-run: op_ready=1, result=0, flags=000, dbg_data=0 for every address, done=0.
- Immediate write → op wsrc=10, imm8=0xF8, rd=3, wr_en=1: done high exactly 1 cycle after accept; dbg R3=0xFFF8; flags and result unchanged.
- Shifted add → preload R1=5, R2=7; op add rn=1, rm=2, shift=01, rd=4, set_flags=1: done 4 cycles after accept; R4=19 (0x0013); flags {Z,V,N}=000.
- Signed overflow → R5=0x8000; op sub rn=5, use_imm, imm5=1, set_flags: result=0x7FFF, flags=010. A second op add of 0x7FFF+sext(imm5=1) gives 0x8000, flags=011.
- Compare without write → R1=R2=9; op sub, wr_en=0, set_flags: flags=100; all registers unchanged. Repeat with set_flags=0: flags hold.
- Busy and reset → pulse op_valid during LDB: op ignored and op_ready=0. Assert rst_n low during EXE: state IDLE, rd not written, done never pulses.

Source files
------------

// File: rtl/datapath_mc_if.sv
// Operation, status and debug bus between the decoder/controller and the
// multi-cycle datapath.
interface datapath_mc_if #(
  parameter int W  = 16,
  parameter int AW = 3
);
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    alu_op;
  logic [1:0]    shift;
  logic [AW-1:0] rn;
  logic [AW-1:0] rm;
  logic [AW-1:0] rd;
  logic [1:0]    wsrc;
  logic          wr_en;
  logic          zero_a;
  logic          use_imm;
  logic          set_flags;
  logic [4:0]    imm5;
  logic [7:0]    imm8;
  logic [W-1:0]  mdata;
  logic [8:0]    pc;
  logic [W-1:0]  result;
  logic [2:0]    flags;
  logic          done;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  modport master (
    output op_valid, alu_op, shift, rn, rm, rd, wsrc, wr_en, zero_a,
           use_imm, set_flags, imm5, imm8, mdata, pc, dbg_addr,
    input  op_ready, result, flags, done, dbg_data
  );

  modport slave (
    input  op_valid, alu_op, shift, rn, rm, rd, wsrc, wr_en, zero_a,
           use_imm, set_flags, imm5, imm8, mdata, pc, dbg_addr,
    output op_ready, result, flags, done, dbg_data
  );
endinterface

// File: rtl/datapath_mc.sv
// Multi-cycle register-file/ALU datapath: one op per handshake, sequenced
// through read A, read B, execute and write-back.
module datapath_mc #(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  datapath_mc_if.slave bus
);
  localparam int NREG = 2 ** AW;

  typedef enum logic [2:0] {IDLE, LDA, LDB, EXE, WB} state_t;

  state_t state, state_nxt;

  logic [W-1:0]  regs [NREG];
  logic [W-1:0]  a_q, b_q, result_q;
  logic [2:0]    flags_q;

  logic [1:0]    alu_op_q, shift_q, wsrc_q;
  logic [AW-1:0] rn_q, rm_q, rd_q;
  logic          wr_en_q, zero_a_q, use_imm_q, set_flags_q;
  logic [4:0]    imm5_q;
  logic [7:0]    imm8_q;
  logic [W-1:0]  mdata_q;
  logic [8:0]    pc_q;

  logic          accept;
  logic [W-1:0]  b_shift, a_in, b_in, alu_out, wb_data;
  logic          alu_v;

  assign bus.op_ready = (state == IDLE);
  assign bus.done     = (state == WB);
  assign bus.result   = result_q;
  assign bus.flags    = flags_q;
  assign bus.dbg_data = regs[bus.dbg_addr];
  assign accept       = bus.op_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Direct write-back sources skip the operand reads and the ALU entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.wsrc == 2'b00) ? LDA : WB;
      LDA:     state_nxt = LDB;
      LDB:     state_nxt = EXE;
      EXE:     state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    b_shift = b_q;
    case (shift_q)
      2'b01:   b_shift = {b_q[W-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_q[W-1:1]};
      2'b11:   b_shift = {b_q[W-1], b_q[W-1:1]};
      default: b_shift = b_q;
    endcase
    a_in    = zero_a_q ? '0 : a_q;
    b_in    = use_imm_q ? {{(W-5){imm5_q[4]}}, imm5_q} : b_shift;
    alu_out = '0;
    alu_v   = 1'b0;
    case (alu_op_q)
      2'b00: begin
        alu_out = a_in + b_in;
        alu_v   = (a_in[W-1] == b_in[W-1]) && (alu_out[W-1] != a_in[W-1]);
      end
      2'b01: begin
        alu_out = a_in - b_in;
        alu_v   = (a_in[W-1] != b_in[W-1]) && (alu_out[W-1] != a_in[W-1]);
      end
      2'b10:   alu_out = a_in & b_in;
      default: alu_out = ~b_in;
    endcase
  end

  always_comb begin
    wb_data = result_q;
    case (wsrc_q)
      2'b01:   wb_data = mdata_q;
      2'b10:   wb_data = W'($signed(imm8_q));
      2'b11:   wb_data = W'(pc_q);
      default: wb_data = result_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      alu_op_q    <= '0;
      shift_q     <= '0;
      wsrc_q      <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      rd_q        <= '0;
      wr_en_q     <= 1'b0;
      zero_a_q    <= 1'b0;
      use_imm_q   <= 1'b0;
      set_flags_q <= 1'b0;
      imm5_q      <= '0;
      imm8_q      <= '0;
      mdata_q     <= '0;
      pc_q        <= '0;
    end else begin
      if (accept) begin
        alu_op_q    <= bus.alu_op;
        shift_q     <= bus.shift;
        wsrc_q      <= bus.wsrc;
        rn_q        <= bus.rn;
        rm_q        <= bus.rm;
        rd_q        <= bus.rd;
        wr_en_q     <= bus.wr_en;
        zero_a_q    <= bus.zero_a;
        use_imm_q   <= bus.use_imm;
        set_flags_q <= bus.set_flags;
        imm5_q      <= bus.imm5;
        imm8_q      <= bus.imm8;
        mdata_q     <= bus.mdata;
        pc_q        <= bus.pc;
      end
      case (state)
        LDA: a_q <= regs[rn_q];
        LDB: b_q <= regs[rm_q];
        EXE: begin
          result_q <= alu_out;
          if (set_flags_q) flags_q <= {(alu_out == '0), alu_v, alu_out[W-1]};
        end
        WB:  if (wr_en_q) regs[rd_q] <= wb_data;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_datapath_mc.sv
// Directed self-checking bench for datapath_mc: direct and ALU write-back,
// shifts, overflow flags, compares, busy handling and mid-op reset.
module tb_datapath_mc;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  datapath_mc_if #(.W(16), .AW(3)) bus ();

  datapath_mc #(.W(16), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_fields(input logic [1:0] alu, input logic [1:0] sh,
                            input logic [2:0] rn, input logic [2:0] rm,
                            input logic [2:0] rd, input logic [1:0] ws,
                            input logic we, input logic za, input logic ui,
                            input logic sf, input logic [4:0] i5,
                            input logic [7:0] i8, input logic [15:0] md,
                            input logic [8:0] pcv);
    bus.alu_op    = alu;
    bus.shift     = sh;
    bus.rn        = rn;
    bus.rm        = rm;
    bus.rd        = rd;
    bus.wsrc      = ws;
    bus.wr_en     = we;
    bus.zero_a    = za;
    bus.use_imm   = ui;
    bus.set_flags = sf;
    bus.imm5      = i5;
    bus.imm8      = i8;
    bus.mdata     = md;
    bus.pc        = pcv;
  endtask

  // After the accept edge the op inputs are garbage; the datapath must not care.
  task automatic scramble();
    bus.op_valid  = 1'b0;
    bus.alu_op    = 2'($urandom);
    bus.shift     = 2'($urandom);
    bus.rn        = 3'($urandom);
    bus.rm        = 3'($urandom);
    bus.rd        = 3'($urandom);
    bus.wsrc      = 2'($urandom);
    bus.wr_en     = 1'($urandom);
    bus.zero_a    = 1'($urandom);
    bus.use_imm   = 1'($urandom);
    bus.set_flags = 1'($urandom);
    bus.imm5      = 5'($urandom);
    bus.imm8      = 8'($urandom);
    bus.mdata     = 16'($urandom);
    bus.pc        = 9'($urandom);
  endtask

  task automatic do_op(input logic [1:0] alu, input logic [1:0] sh,
                       input logic [2:0] rn, input logic [2:0] rm,
                       input logic [2:0] rd, input logic [1:0] ws,
                       input logic we, input logic za, input logic ui,
                       input logic sf, input logic [4:0] i5,
                       input logic [7:0] i8, input logic [15:0] md,
                       input logic [8:0] pcv, output int lat);
    set_fields(alu, sh, rn, rm, rd, ws, we, za, ui, sf, i5, i8, md, pcv);
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    scramble();
    lat = 99;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_imm(input logic [2:0] rd, input logic [7:0] val);
    int lat;
    do_op(2'b00, 2'b00, 3'd0, 3'd0, rd, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0,
          5'd0, val, 16'h0, 9'h0, lat);
  endtask

  task automatic test_imm_write();
    int lat;
    do_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1,
          5'd0, 8'hF8, 16'h0, 9'h0, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("[TB] FAIL imm_latency got=%0d exp=1", lat);
    end
    bus.dbg_addr = 3'd3;
    #1;
    checks++;
    if (bus.dbg_data !== 16'hFFF8) begin
      errors++;
      $display("[TB] FAIL imm_r3 got=%h exp=fff8", bus.dbg_data);
    end
    checks++;
    if (bus.result !== 16'h0 || bus.flags !== 3'b000) begin
      errors++;
      $display("[TB] FAIL imm_untouched got result=%h flags=%b exp 0000/000",
               bus.result, bus.flags);
    end
    do_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0,
          5'd0, 8'h0, 16'h8000, 9'h0, lat);
    do_op(2'b00, 2'b00, 3'd0, 3'd0, 3'd6, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0,
          5'd0, 8'h0, 16'h0, 9'h1A5, lat);
    bus.dbg_addr = 3'd5;
    #1;
    checks++;
    if (bus.dbg_data !== 16'h8000) begin
      errors++;
      $display("[TB] FAIL mdata_r5 got=%h exp=8000", bus.dbg_data);
    end
    bus.dbg_addr = 3'd6;
    #1;
    checks++;
    if (bus.dbg_data !== 16'h01A5) begin
      errors++;
      $display("[TB] FAIL pc_r6 got=%h exp=01a5", bus.dbg_data);
    end
  endtask

  task automatic test_shift_add();
    int lat;
    load_imm(3'd1, 8'd5);
    load_imm(3'd2, 8'd7);
    do_op(2'b00, 2'b01, 3'd1, 3'd2, 3'd4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1,
          5'd0, 8'h0, 16'h0, 9'h0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL add_latency got=%0d exp=4", lat);
    end
    bus.dbg_addr = 3'd4;
    #1;
    checks++;
    if (bus.dbg_data !== 16'h0013 || bus.result !== 16'h0013) begin
      errors++;
      $display("[TB] FAIL add_r4 got r4=%h result=%h exp=0013",
               bus.dbg_data, bus.result);
    end
    checks++;
    if (bus.flags !== 3'b000) begin
      errors++;
      $display("[TB] FAIL add_flags got=%b exp=000", bus.flags);
    end
    // not(asr1(0xFFF8)) = not(0xFFFC) = 0x0003 into R7
    do_op(2'b11, 2'b11, 3'd0, 3'd3, 3'd7, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1,
          5'd0, 8'h0, 16'h0, 9'h0, lat);
    bus.dbg_addr = 3'd7;
    #1;
    checks++;
    if (bus.dbg_data !== 16'h0003) begin
      errors++;
      $display("[TB] FAIL not_asr_r7 got=%h exp=0003", bus.dbg_data);
    end
    // 0 + lsr1(0xFFF8) with zero_a, no write
    do_op(2'b00, 2'b10, 3'd4, 3'd3, 3'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1,
          5'd0, 8'h0, 16'h0, 9'h0, lat);
    checks++;
    if (bus.result !== 16'h7FFC || bus.flags !== 3'b000) begin
      errors++;
      $display("[TB] FAIL lsr_zero_a got result=%h flags=%b exp 7ffc/000",
               bus.result, bus.flags);
    end
    // and(0x0013, 0x0007) = 0x0003 into R0
    do_op(2'b10, 2'b00, 3'd4, 3'd2, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1,
          5'd0, 8'h0, 16'h0, 9'h0, lat);
    bus.dbg_addr = 3'd0;
    #1;
    checks++;
    if (bus.dbg_data !== 16'h0003) begin
      errors++;
      $display("[TB] FAIL and_r0 got=%h exp=0003", bus.dbg_data);
    end
  endtask

  task automatic test_overflow();
    int lat;
    do_op(2'b01, 2'b00, 3'd5, 3'd0, 3'd6, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1,
          5'd1, 8'h0, 16'h0, 9'h0, lat);
    checks++;
    if (bus.result !== 16'h7FFF || bus.flags !== 3'b010) begin
      errors++;
      $display("[TB] FAIL sub_ovf got result=%h flags=%b exp 7fff/010",
               bus.result, bus.flags);
    end
    do_op(2'b00, 2'b00, 3'd6, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1,
          5'd1, 8'h0, 16'h0, 9'h0, lat);
    checks++;
    if (bus.result !== 16'h8000 || bus.flags !== 3'b011) begin
      errors++;
      $display("[TB] FAIL add_ovf got result=%h flags=%b exp 8000/011",
               bus.result, bus.flags);
    end
  endtask

  task automatic test_reset();
    set_fields(2'b01, 2'b00, 3'd1, 3'd2, 3'd7, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1,
               5'd0, 8'h0, 16'h0, 9'h0);
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    scramble();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 16'h0 || bus.flags !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got done=%b result=%h flags=%b exp 0/0000/000",
               bus.done, bus.result, bus.flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.op_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got=%b exp=1", bus.op_ready);
    end
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      checks++;
      if (bus.dbg_data !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_reg%0d got=%h exp=0000", i, bus.dbg_data);
      end
    end
  endtask

  task automatic test_compare();
    int lat;
    logic [15:0] exp_regs [8];
    load_imm(3'd1, 8'd9);
    load_imm(3'd2, 8'd9);
    for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0;
    exp_regs[1] = 16'd9;
    exp_regs[2] = 16'd9;
    do_op(2'b01, 2'b00, 3'd1, 3'd2, 3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1,
          5'd0, 8'h0, 16'h0, 9'h0, lat);
    checks++;
    if (lat !== 4 || bus.flags !== 3'b100 || bus.result !== 16'h0) begin
      errors++;
      $display("[TB] FAIL cmp_flags got lat=%0d flags=%b result=%h exp 4/100/0000",
               lat, bus.flags, bus.result);
    end
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      checks++;
      if (bus.dbg_data !== exp_regs[i]) begin
        errors++;
        $display("[TB] FAIL cmp_reg%0d got=%h exp=%h", i, bus.dbg_data, exp_regs[i]);
      end
    end
    // 9 - sext(4) = 5 with flags held
    do_op(2'b01, 2'b00, 3'd1, 3'd2, 3'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0,
          5'd4, 8'h0, 16'h0, 9'h0, lat);
    checks++;
    if (bus.result !== 16'h0005 || bus.flags !== 3'b100) begin
      errors++;
      $display("[TB] FAIL cmp_hold got result=%h flags=%b exp 0005/100",
               bus.result, bus.flags);
    end
  endtask

  task automatic test_busy_reset();
    int lat;
    int done_cnt;
    set_fields(2'b00, 2'b00, 3'd1, 3'd2, 3'd4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0,
               5'd0, 8'h0, 16'h0, 9'h0);
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    scramble();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.op_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_ready got=%b exp=0", bus.op_ready);
    end
    set_fields(2'b00, 2'b00, 3'd0, 3'd0, 3'd7, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0,
               5'd0, 8'h55, 16'h0, 9'h0);
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    lat = 99;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("[TB] FAIL busy_done got=%0d exp=2", lat);
    end
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL busy_queued got=%0d exp=0", done_cnt);
    end
    bus.dbg_addr = 3'd4;
    #1;
    checks++;
    if (bus.dbg_data !== 16'd18) begin
      errors++;
      $display("[TB] FAIL busy_r4 got=%h exp=0012", bus.dbg_data);
    end
    bus.dbg_addr = 3'd7;
    #1;
    checks++;
    if (bus.dbg_data !== 16'h0) begin
      errors++;
      $display("[TB] FAIL busy_r7 got=%h exp=0000", bus.dbg_data);
    end
    // reset lands while the next op is in EXE
    set_fields(2'b00, 2'b00, 3'd1, 3'd2, 3'd5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1,
               5'd0, 8'h0, 16'h0, 9'h0);
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    scramble();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.op_ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exe_reset got ready=%b done=%b exp 1/0",
               bus.op_ready, bus.done);
    end
    done_cnt = 0;
    @(negedge clk);
    if (bus.done) done_cnt++;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL exe_reset_done got=%0d exp=0", done_cnt);
    end
    bus.dbg_addr = 3'd5;
    #1;
    checks++;
    if (bus.dbg_data !== 16'h0) begin
      errors++;
      $display("[TB] FAIL exe_reset_r5 got=%h exp=0000", bus.dbg_data);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.dbg_addr = 3'd0;
    set_fields(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
               5'd0, 8'h0, 16'h0, 9'h0);
    bus.op_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] imm write");
    test_imm_write();
    $display("[TB] shifted add");
    test_shift_add();
    $display("[TB] overflow");
    test_overflow();
    $display("[TB] reset mid-run");
    test_reset();
    $display("[TB] compare");
    test_compare();
    $display("[TB] busy and reset");
    test_busy_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
